mod_serial: RTL

Parametrised bit-serial modulo unit. Computes `serial_in mod M` for a WIDTH-bit operand and a run-time modulus M taken from `configure`. Operand bits are consumed MSB-first, one per enabled clock. Generalises the fixed mod-7 divider with a parametrised operand width and modulus range, a start/busy/done handshake, clock-enable stalling and an invalid-modulus error flag. Sits between the switch/register input stage and the seven-segment/LED output stage.

---
 rtl/mod_serial_if.sv | 42 ++++
 rtl/mod_serial.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mod_serial_if.sv
// Handshake and data bundle for the bit-serial modulo unit.
// The master side drives the request; the slave side is the modulo unit.
interface mod_serial_if #(
  parameter int WIDTH = 32,
  parameter int MOD_W = 4
) ();

  logic             enable;
  logic             start;
  logic [MOD_W-1:0] configure;
  logic [WIDTH-1:0] serial_in;
  logic             busy;
  logic [MOD_W-1:0] out;
  logic             cnt_out;
  logic             led;
  logic             err;

  modport master (
    output enable,
    output start,
    output configure,
    output serial_in,
    input  busy,
    input  out,
    input  cnt_out,
    input  led,
    input  err
  );

  modport slave (
    input  enable,
    input  start,
    input  configure,
    input  serial_in,
    output busy,
    output out,
    output cnt_out,
    output led,
    output err
  );

endinterface

// File: rtl/mod_serial.sv
// Bit-serial modulo unit: computes serial_in mod M, consuming the operand
// MSB-first one bit per enabled clock. Uses one conditional subtract per bit
// because the running remainder always stays below M.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for start; start is only sampled here
//   ST_RUN  | shifting operand bits through the remainder, busy=1
//   ST_DONE | one-cycle completion pulse on cnt_out, then back to idle
module mod_serial #(
  parameter int WIDTH = 32,
  parameter int MOD_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  mod_serial_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sh,    sh_nx;
  logic [MOD_W-1:0] m_q,   m_nx;
  logic [MOD_W-1:0] r,     r_nx;
  logic [CNT_W-1:0] cnt,   cnt_nx;
  logic [MOD_W-1:0] out_q, out_nx;
  logic             led_q, led_nx;
  logic             err_q, err_nx;

  // One remainder step: t = 2r + b is one bit wider than r, and since r < M
  // we have t < 2M, so a single subtract of M brings it back into range.
  logic [MOD_W:0]   t;
  logic [MOD_W:0]   t_sub;
  logic [MOD_W-1:0] r_step;

  // Combinational remainder step for the current operand MSB.
  always_comb begin
    t      = {r, sh[WIDTH-1]};
    t_sub  = t - {1'b0, m_q};
    r_step = t[MOD_W-1:0];
    if (t >= {1'b0, m_q}) begin
      r_step = t_sub[MOD_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and datapath next values; everything holds unless a case moves it.
  always_comb begin
    state_nx = state;
    sh_nx    = sh;
    m_nx     = m_q;
    r_nx     = r;
    cnt_nx   = cnt;
    out_nx   = out_q;
    led_nx   = led_q;
    err_nx   = err_q;

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.configure != '0) begin
            sh_nx    = bus.serial_in;
            m_nx     = bus.configure;
            r_nx     = '0;
            cnt_nx   = CNT_W'(WIDTH);
            state_nx = ST_RUN;
          end else begin
            // Modulus of zero is meaningless: report it and finish at once.
            out_nx   = '0;
            led_nx   = 1'b0;
            err_nx   = 1'b1;
            state_nx = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (bus.enable) begin
          sh_nx  = {sh[WIDTH-2:0], 1'b0};
          r_nx   = r_step;
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            out_nx   = r_step;
            led_nx   = (r_step == '0);
            err_nx   = 1'b0;
            state_nx = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Datapath and result registers; reset also clears the visible result.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh    <= '0;
      m_q   <= '0;
      r     <= '0;
      cnt   <= '0;
      out_q <= '0;
      led_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sh    <= sh_nx;
      m_q   <= m_nx;
      r     <= r_nx;
      cnt   <= cnt_nx;
      out_q <= out_nx;
      led_q <= led_nx;
      err_q <= err_nx;
    end
  end

  assign bus.busy    = (state == ST_RUN);
  assign bus.cnt_out = (state == ST_DONE);
  assign bus.out     = out_q;
  assign bus.led     = led_q;
  assign bus.err     = err_q;

endmodule
